decode_dispatch_queue: RTL and testbench

- Consumer end of the decode stage-2 muxed instruction bus.
- Accepts one decoded instruction per cycle (format, opcodes, regs, imm, flags, functional unit code) into an in-order FIFO.
- Dispatches the FIFO head to exactly one functional unit, selected by its 3-bit code, over a per-unit valid/ready handshake.
- Applies back-pressure to decode via stall_o.

---
 rtl/decode_dispatch_queue.sv | 150 +++++++++++++++
 tb/tb_decode_dispatch_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_dispatch_queue.sv
// In-order dispatch FIFO at the consumer end of the decode stage-2 bus; issues the head to one FU.
// Optional DISPATCH_PERF_CNT_EN adds dispatch and stall-cycle counters.
module decode_dispatch_queue #(
  parameter int DEPTH            = 4,
  parameter int opcodeWidth      = 6,
  parameter int regWidth         = 5,
  parameter int immWidth         = 16,
  parameter int XxoOpcodeWidth   = 10,
  parameter int formatIndexRange = 5,
  parameter int NUM_FU           = 8
) (
  input  logic                        clock_i,
  input  logic                        reset_n_i,
  input  logic                        enable_i,
  input  logic [63:0]                 instructionAddress_i,
  input  logic [opcodeWidth-1:0]      opcode_i,
  input  logic [XxoOpcodeWidth-1:0]   xOpcode_i,
  input  logic                        xOpcodeEnable_i,
  input  logic [formatIndexRange-1:0] instructionFormat_i,
  input  logic [2:0]                  functionalUnitCode_i,
  input  logic [regWidth-1:0]         reg1_i,
  input  logic [regWidth-1:0]         reg2_i,
  input  logic [regWidth-1:0]         reg3_i,
  input  logic [2:0]                  regEnables_i,
  input  logic [immWidth-1:0]         imm_i,
  input  logic [5:0]                  flags_i,
  input  logic                        reg2ValOrZero_i,
  output logic                        stall_o,
  output logic [NUM_FU-1:0]           fuValid_o,
  input  logic [NUM_FU-1:0]           fuReady_i,
  output logic [63:0]                 instructionAddress_o,
  output logic [opcodeWidth-1:0]      opcode_o,
  output logic [XxoOpcodeWidth-1:0]   xOpcode_o,
  output logic                        xOpcodeEnable_o,
  output logic [formatIndexRange-1:0] instructionFormat_o,
  output logic [2:0]                  functionalUnitCode_o,
  output logic [regWidth-1:0]         reg1_o,
  output logic [regWidth-1:0]         reg2_o,
  output logic [regWidth-1:0]         reg3_o,
  output logic [2:0]                  regEnables_o,
  output logic [immWidth-1:0]         imm_o,
  output logic [5:0]                  flags_o,
  output logic                        reg2ValOrZero_o,
`ifdef DISPATCH_PERF_CNT_EN
  output logic [31:0]                 dispatchCount_o,
  output logic [31:0]                 stallCycles_o,
`endif
  output logic                        invalidDrop_o,
  output logic                        overflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [63:0]                 addr;
    logic [opcodeWidth-1:0]      opc;
    logic [XxoOpcodeWidth-1:0]   xopc;
    logic                        xen;
    logic [formatIndexRange-1:0] fmt;
    logic [2:0]                  fu;
    logic [regWidth-1:0]         r1;
    logic [regWidth-1:0]         r2;
    logic [regWidth-1:0]         r3;
    logic [2:0]                  ren;
    logic [immWidth-1:0]         imm;
    logic [5:0]                  flags;
    logic                        r2z;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wrptr, r_rdptr;
  logic [CW-1:0]   r_count;
  logic            r_stall, r_invalid, r_overflow;

  entry_t          w_head, w_in;
  logic            w_deq, w_enq, w_valid_fmt;
  logic [CW-1:0]   w_cnt_nxt;

  assign w_head      = r_mem[r_rdptr];
  assign w_valid_fmt = (instructionFormat_i != '0);
  assign w_deq       = (r_count != '0) && fuReady_i[w_head.fu];
  assign w_enq       = enable_i && w_valid_fmt && ((r_count < CW'(DEPTH)) || w_deq);

  assign w_in = '{addr: instructionAddress_i, opc: opcode_i, xopc: xOpcode_i,
                  xen: xOpcodeEnable_i, fmt: instructionFormat_i, fu: functionalUnitCode_i,
                  r1: reg1_i, r2: reg2_i, r3: reg3_i, ren: regEnables_i, imm: imm_i,
                  flags: flags_i, r2z: reg2ValOrZero_i};

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_enq && !w_deq)      w_cnt_nxt = r_count + CW'(1);
    else if (!w_enq && w_deq) w_cnt_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wrptr    <= '0;
      r_rdptr    <= '0;
      r_count    <= '0;
      r_stall    <= 1'b0;
      r_invalid  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_enq) begin
        r_mem[r_wrptr] <= w_in;
        r_wrptr        <= r_wrptr + PW'(1);
      end
      if (w_deq) r_rdptr <= r_rdptr + PW'(1);
      r_count   <= w_cnt_nxt;
      // One slot of headroom covers the decode stage's register latency.
      r_stall   <= (w_cnt_nxt >= CW'(DEPTH - 1));
      r_invalid <= enable_i && !w_valid_fmt;
      if (enable_i && w_valid_fmt && !w_enq) r_overflow <= 1'b1;
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] r_dispatch_cnt, r_stall_cnt;
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_dispatch_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_deq)   r_dispatch_cnt <= r_dispatch_cnt + 32'd1;
      if (r_stall) r_stall_cnt    <= r_stall_cnt + 32'd1;
    end
  end
  assign dispatchCount_o = r_dispatch_cnt;
  assign stallCycles_o   = r_stall_cnt;
`endif

  assign fuValid_o            = (r_count != '0) ? (NUM_FU'(1) << w_head.fu) : '0;
  assign stall_o              = r_stall;
  assign invalidDrop_o        = r_invalid;
  assign overflow_o           = r_overflow;
  assign instructionAddress_o = w_head.addr;
  assign opcode_o             = w_head.opc;
  assign xOpcode_o            = w_head.xopc;
  assign xOpcodeEnable_o      = w_head.xen;
  assign instructionFormat_o  = w_head.fmt;
  assign functionalUnitCode_o = w_head.fu;
  assign reg1_o               = w_head.r1;
  assign reg2_o               = w_head.r2;
  assign reg3_o               = w_head.r3;
  assign regEnables_o         = w_head.ren;
  assign imm_o                = w_head.imm;
  assign flags_o              = w_head.flags;
  assign reg2ValOrZero_o      = w_head.r2z;
endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Directed bench for decode_dispatch_queue: reset, dispatch, full/skid, overflow, invalid drop, blocked head.
module tb_decode_dispatch_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [63:0] addr;
  logic [5:0]  opc;
  logic [9:0]  xopc;
  logic        xen;
  logic [4:0]  fmt;
  logic [2:0]  fu;
  logic [4:0]  r1, r2, r3;
  logic [2:0]  ren;
  logic [15:0] imm;
  logic [5:0]  flags;
  logic        r2z;
  logic        stall;
  logic [7:0]  fu_valid;
  logic [7:0]  fu_ready;
  logic [63:0] addr_o;
  logic [5:0]  opc_o;
  logic [9:0]  xopc_o;
  logic        xen_o;
  logic [4:0]  fmt_o;
  logic [2:0]  fu_o;
  logic [4:0]  r1_o, r2_o, r3_o;
  logic [2:0]  ren_o;
  logic [15:0] imm_o;
  logic [5:0]  flags_o;
  logic        r2z_o;
  logic        inv_drop;
  logic        overflow;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] disp_cnt, stall_cnt;
  logic [31:0] disp_before;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_dispatch_queue dut (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable),
    .instructionAddress_i(addr), .opcode_i(opc), .xOpcode_i(xopc),
    .xOpcodeEnable_i(xen), .instructionFormat_i(fmt), .functionalUnitCode_i(fu),
    .reg1_i(r1), .reg2_i(r2), .reg3_i(r3), .regEnables_i(ren), .imm_i(imm),
    .flags_i(flags), .reg2ValOrZero_i(r2z),
    .stall_o(stall), .fuValid_o(fu_valid), .fuReady_i(fu_ready),
    .instructionAddress_o(addr_o), .opcode_o(opc_o), .xOpcode_o(xopc_o),
    .xOpcodeEnable_o(xen_o), .instructionFormat_o(fmt_o), .functionalUnitCode_o(fu_o),
    .reg1_o(r1_o), .reg2_o(r2_o), .reg3_o(r3_o), .regEnables_o(ren_o), .imm_o(imm_o),
    .flags_o(flags_o), .reg2ValOrZero_o(r2z_o),
`ifdef DISPATCH_PERF_CNT_EN
    .dispatchCount_o(disp_cnt), .stallCycles_o(stall_cnt),
`endif
    .invalidDrop_o(inv_drop), .overflow_o(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one instruction; secondary fields are derived from reg1 so the head is recognisable.
  task automatic drive(input logic [4:0] f, input logic [2:0] u, input logic [4:0] a, input logic [15:0] im);
    enable = 1'b1;
    fmt    = f;
    fu     = u;
    r1     = a;
    r2     = a + 5'd1;
    r3     = a + 5'd2;
    imm    = im;
    addr   = {32'hA000_0000, 27'd0, a};
    opc    = {1'b1, a};
    xopc   = {5'h15, a};
    xen    = 1'b1;
    ren    = 3'b101;
    flags  = 6'b100110;
    r2z    = 1'b1;
  endtask

  task automatic idle();
    enable = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    fu_ready = 8'h00;
    drive(5'd3, 3'd2, 5'd9, 16'hBEEF);
    repeat (3) step();
    chk("rst_fuvalid", 64'(fu_valid), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_invdrop", 64'(inv_drop), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_imm", 64'(imm_o), 64'h0);
    chk("rst_reg1", 64'(r1_o), 64'h0);
    chk("rst_addr", addr_o, 64'h0);
    // Release mid-cycle with enable still high; nothing may appear before the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_fuvalid", 64'(fu_valid), 64'h0);
    chk("rel_stall", 64'(stall), 64'h0);
    idle();

    // Single instruction, dispatched the cycle after it appears
    step();
    drive(5'd3, 3'd2, 5'd1, 16'h1234);
    fu_ready = 8'h04;
    step();
    idle();
    chk("one_fuvalid", 64'(fu_valid), 64'h04);
    chk("one_imm", 64'(imm_o), 64'h1234);
    chk("one_fmt", 64'(fmt_o), 64'h3);
    chk("one_fu", 64'(fu_o), 64'h2);
    chk("one_addr", addr_o, 64'hA000_0000_0000_0001);
    chk("one_opc", 64'(opc_o), 64'h21);
    chk("one_xopc", 64'(xopc_o), 64'h2A1);
    chk("one_reg2", 64'(r2_o), 64'h2);
    chk("one_reg3", 64'(r3_o), 64'h3);
    chk("one_ren", 64'(ren_o), 64'h5);
    chk("one_flags", 64'(flags_o), 64'h26);
    chk("one_xen_r2z", 64'({xen_o, r2z_o}), 64'h3);
    chk("one_stall", 64'(stall), 64'h0);
    step();
    chk("one_drained", 64'(fu_valid), 64'h0);

    // Fill to DEPTH with no ready; stall rises after the third enqueue
    fu_ready = 8'h00;
    drive(5'd3, 3'd1, 5'd1, 16'h0001);
    step();
    chk("fill1_stall", 64'(stall), 64'h0);
    drive(5'd3, 3'd1, 5'd2, 16'h0002);
    step();
    chk("fill2_stall", 64'(stall), 64'h0);
    drive(5'd3, 3'd1, 5'd3, 16'h0003);
    step();
    chk("fill3_stall", 64'(stall), 64'h1);
    drive(5'd3, 3'd1, 5'd4, 16'h0004);
    step();
    chk("fill4_stall", 64'(stall), 64'h1);
    chk("fill4_head", 64'(r1_o), 64'h1);
    chk("fill4_fuvalid", 64'(fu_valid), 64'h02);

    // Full plus simultaneous dispatch: legal, no overflow
    drive(5'd3, 3'd1, 5'd5, 16'h0005);
    fu_ready = 8'h02;
    step();
    idle();
    chk("swap_overflow", 64'(overflow), 64'h0);
    chk("swap_stall", 64'(stall), 64'h1);
    chk("seq_2", 64'(r1_o), 64'h2);
    step();
    chk("seq_3", 64'(r1_o), 64'h3);
    chk("drain3_stall", 64'(stall), 64'h1);
    step();
    chk("seq_4", 64'(r1_o), 64'h4);
    chk("drain2_stall", 64'(stall), 64'h0);
    step();
    chk("seq_5", 64'(r1_o), 64'h5);
    step();
    chk("seq_empty", 64'(fu_valid), 64'h0);

    // Overflow: fifth arrival into a full queue is dropped
    fu_ready = 8'h00;
    for (int i = 0; i < 4; i++) begin
      drive(5'd3, 3'd1, 5'(11 + i), 16'h0);
      step();
    end
    chk("ovf_before", 64'(overflow), 64'h0);
    drive(5'd3, 3'd1, 5'd15, 16'h0);
    step();
    idle();
    chk("ovf_set", 64'(overflow), 64'h1);
    chk("ovf_head", 64'(r1_o), 64'hB);
    fu_ready = 8'h02;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", 64'(r1_o), 64'(11 + i));
      step();
    end
    chk("ovf_dropped", 64'(fu_valid), 64'h0);
    chk("ovf_sticky", 64'(overflow), 64'h1);

    // INVALID format is discarded with a one-cycle pulse
    drive(5'd0, 3'd3, 5'd20, 16'h0);
    step();
    idle();
    chk("inv_pulse", 64'(inv_drop), 64'h1);
    chk("inv_not_queued", 64'(fu_valid), 64'h0);
    step();
    chk("inv_pulse_end", 64'(inv_drop), 64'h0);
    chk("inv_still_empty", 64'(fu_valid), 64'h0);

    // Blocked head: other units ready must not dispatch it
    fu_ready = 8'hDF;
    drive(5'd3, 3'd5, 5'd7, 16'h0);
    step();
    idle();
`ifdef DISPATCH_PERF_CNT_EN
    disp_before = disp_cnt;
`endif
    for (int i = 0; i < 10; i++) begin
      chk("blk_hold", 64'(fu_valid), 64'h20);
      step();
    end
    chk("blk_head", 64'(r1_o), 64'h7);
    fu_ready = 8'h20;
    step();
    chk("blk_dispatched", 64'(fu_valid), 64'h0);
`ifdef DISPATCH_PERF_CNT_EN
    chk("perf_dispatch", 64'(disp_cnt - disp_before), 64'h1);
`endif

    // Reset mid-operation drops fuValid asynchronously
    fu_ready = 8'h00;
    drive(5'd3, 3'd4, 5'd3, 16'h0);
    step();
    idle();
    chk("mid_valid", 64'(fu_valid), 64'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fuvalid", 64'(fu_valid), 64'h0);
    chk("mid_rst_overflow", 64'(overflow), 64'h0);
    chk("mid_rst_reg1", 64'(r1_o), 64'h0);
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
